uart_cmd_parser: RTL and testbench
==================================

// Module: uart_cmd_parser
// PURPOSE
//  Consumes bytes from the UART receiver; decodes frames FE,L,CMD,payload,EF.
//  Sets matrix size N, streams matrix bytes into the matrix FIFO, requests results.
//  Sits between the UART Rx byte output and the matrix FIFO/compute control.
// PARAMETERS
//  START_BYTE      8'hFE  frame start marker
//  END_BYTE        8'hEF  frame end marker
//  N_MAX           8      largest legal matrix size N
//  TIMEOUT_CYCLES  64     inter-byte timeout, clk cycles (TIMEOUT_EN only)
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  rx_data        in   8  received byte, valid with rx_valid
//  rx_valid       in   1  one-cycle strobe per received byte
//  rx_parity_err  in   1  parity error for the byte strobed by rx_valid
//  mat_full       in   1  matrix FIFO full
//  mat_push       out  1  push strobe to matrix FIFO
//  mat_data       out  8  matrix byte, valid with mat_push
//  mat_done       out  1  pulse: matrix frame closed correctly
//  mat_abort      out  1  pulse: matrix frame failed; downstream flushes FIFO
//  n_value        out  4  current N (reset 0)
//  n_valid        out  1  pulse: n_value updated
//  result_req     out  1  pulse: result transmission requested
//  busy           out  1  high whenever state != IDLE
//  err            out  1  pulse: frame error
//  err_code       out  3  held until next err: 1 parity, 2 bad END, 3 bad CMD/arg, 4 length, 5 overflow, 6 timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0.
//  - All outputs registered; each pulse is 1 cycle, asserted the cycle after the causing rx_valid.
//  - States: IDLE, LEN, CMD, PAYLOAD, END, DISCARD. Only rx_valid cycles advance state.
//  - IDLE: byte==START_BYTE -> LEN; any other byte ignored, no err.
//  - LEN: store L; plen = (L>=2) ? L-2 : 0 (L counts CMD..END inclusive) -> CMD.
//  - CMD 0x01: requires plen==1, else err 4 -> DISCARD.
//  - CMD 0x02: requires plen==0, else err 4 -> DISCARD.
//  - CMD 0x04: requires n_value!=0 and plen==n_value*n_value, else err 4 -> DISCARD.
//  - Any other CMD: err 3 -> DISCARD.
//  - Valid CMD: plen>0 -> PAYLOAD, else END.
//  - PAYLOAD 0x01: byte held as N candidate; 1<=byte<=N_MAX else err 3 -> DISCARD.
//  - PAYLOAD 0x04: each byte -> mat_push/mat_data, in arrival order.
//  - PAYLOAD 0x04 with mat_full=1 at that byte: no push, err 5, mat_abort -> IDLE.
//  - PAYLOAD: 8-bit down-counter of plen; reaching 0 -> END.
//  - END byte==END_BYTE: 0x01 sets n_value + n_valid; 0x02 pulses result_req; 0x04 pulses mat_done.
//  - END byte!=END_BYTE: err 2, no command effect (0x04 also pulses mat_abort) -> IDLE.
//  - DISCARD: consumes remaining plen bytes plus END byte silently -> IDLE.
//  - rx_parity_err on any non-IDLE byte: err 1 (0x04 in PAYLOAD/END also mat_abort) -> IDLE.
//  - rx_parity_err in IDLE: byte ignored.
//  - START_BYTE inside a frame is plain data; no resync.
//  - n_value changes only on a fully valid 0x01 frame.
//  - Async reset mid-frame: immediate IDLE; partial frame lost; no pulses emitted.
// CONFIGURATION
//  UART_CMD_TIMEOUT_EN defined: cycle counter clears on every rx_valid and in IDLE.
//    Reaching TIMEOUT_CYCLES outside IDLE: err 6 (mat_abort if CMD 0x04 accepted) -> IDLE.
//    rx_valid in the expiry cycle wins: byte processed, no timeout.
//  UART_CMD_TIMEOUT_EN undefined: no counter; parser waits indefinitely; code 6 never produced.
// TESTING
//  1. FE 03 01 04 EF -> n_value=4; one n_valid pulse after EF; err never asserted.
//  2. N=4; FE 12 04 00..0F EF -> 16 mat_push, data 00..0F in order; mat_done once; no abort.
//  3. FE 01 02 EF, then FE 02 02 EF -> result_req pulses exactly twice; busy low between frames.
//  4. FE 03 01 05 AA -> err_code=2; n_value stays 4; next FE 03 01 02 EF -> n_value=2.
//  5. N=4; FE 12 04 00 01 02 03, mat_full=1 on 5th byte -> 4 pushes, err_code=5, mat_abort; next frame OK.
//  6. Parity error on CMD -> err_code=1, IDLE.
//     TIMEOUT_EN: FE 03, then 64 idle cycles -> err_code=6, busy low.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and result bundle between the UART receiver side and the command parser.
// master = byte source / downstream consumer, slave = parser.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       mat_full;
  logic       mat_push;
  logic [7:0] mat_data;
  logic       mat_done;
  logic       mat_abort;
  logic [3:0] n_value;
  logic       n_valid;
  logic       result_req;
  logic       busy;
  logic       err;
  logic [2:0] err_code;

  modport master (
    output rx_data, rx_valid, rx_parity_err, mat_full,
    input  mat_push, mat_data, mat_done, mat_abort, n_value, n_valid,
           result_req, busy, err, err_code
  );

  modport slave (
    input  rx_data, rx_valid, rx_parity_err, mat_full,
    output mat_push, mat_data, mat_done, mat_abort, n_value, n_valid,
           result_req, busy, err, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame decoder FE,L,CMD,payload,EF: sets matrix size N, streams matrix bytes, requests results.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter logic [7:0]  START_BYTE = 8'hFE,
  parameter logic [7:0]  END_BYTE   = 8'hEF,
  parameter int unsigned N_MAX      = 8
`ifdef UART_CMD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input logic              clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);

  localparam logic [7:0] CMD_SETN = 8'h01;
  localparam logic [7:0] CMD_RES  = 8'h02;
  localparam logic [7:0] CMD_MAT  = 8'h04;

  localparam logic [2:0] E_PARITY = 3'd1;
  localparam logic [2:0] E_END    = 3'd2;
  localparam logic [2:0] E_CMD    = 3'd3;
  localparam logic [2:0] E_LEN    = 3'd4;
  localparam logic [2:0] E_OVF    = 3'd5;
  localparam logic [2:0] E_TMO    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_END, S_DISCARD
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] plen_q, plen_d;
  logic [3:0] n_cand_q, n_cand_d;
  logic [3:0] n_value_q, n_value_d;
  logic [7:0] mat_data_q, mat_data_d;
  logic [2:0] err_code_q, err_code_d;
  logic       mat_push_q, mat_push_d;
  logic       mat_done_q, mat_done_d;
  logic       mat_abort_q, mat_abort_d;
  logic       n_valid_q, n_valid_d;
  logic       result_req_q, result_req_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;

  logic [7:0] n_sq_c;
  logic       mat_active_c;
  logic       tmo_fire_c;

  assign n_sq_c       = {4'd0, n_value_q} * {4'd0, n_value_q};
  // A matrix transfer is in flight only once CMD 0x04 has been accepted.
  assign mat_active_c = (cmd_q == CMD_MAT) && ((state_q == S_PAYLOAD) || (state_q == S_END));

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (bus.rx_valid || (state_q == S_IDLE)) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign tmo_fire_c = (state_q != S_IDLE) && !bus.rx_valid &&
                      (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_fire_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      plen_q       <= '0;
      n_cand_q     <= '0;
      n_value_q    <= '0;
      mat_data_q   <= '0;
      err_code_q   <= '0;
      mat_push_q   <= 1'b0;
      mat_done_q   <= 1'b0;
      mat_abort_q  <= 1'b0;
      n_valid_q    <= 1'b0;
      result_req_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      plen_q       <= plen_d;
      n_cand_q     <= n_cand_d;
      n_value_q    <= n_value_d;
      mat_data_q   <= mat_data_d;
      err_code_q   <= err_code_d;
      mat_push_q   <= mat_push_d;
      mat_done_q   <= mat_done_d;
      mat_abort_q  <= mat_abort_d;
      n_valid_q    <= n_valid_d;
      result_req_q <= result_req_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    plen_d       = plen_q;
    n_cand_d     = n_cand_q;
    n_value_d    = n_value_q;
    mat_data_d   = mat_data_q;
    err_code_d   = err_code_q;
    mat_push_d   = 1'b0;
    mat_done_d   = 1'b0;
    mat_abort_d  = 1'b0;
    n_valid_d    = 1'b0;
    result_req_d = 1'b0;
    err_d        = 1'b0;

    if (bus.rx_valid) begin
      if ((state_q != S_IDLE) && bus.rx_parity_err) begin
        err_d       = 1'b1;
        err_code_d  = E_PARITY;
        mat_abort_d = mat_active_c;
        state_d     = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!bus.rx_parity_err && (bus.rx_data == START_BYTE)) state_d = S_LEN;
          end
          S_LEN: begin
            plen_d  = (bus.rx_data >= 8'd2) ? (bus.rx_data - 8'd2) : 8'd0;
            state_d = S_CMD;
          end
          S_CMD: begin
            cmd_d   = bus.rx_data;
            state_d = (plen_q != 8'd0) ? S_PAYLOAD : S_END;
            // Any rejection drops into DISCARD to swallow the rest of the frame.
            if ((bus.rx_data != CMD_SETN) && (bus.rx_data != CMD_RES) &&
                (bus.rx_data != CMD_MAT)) begin
              err_d      = 1'b1;
              err_code_d = E_CMD;
              state_d    = S_DISCARD;
            end else if (((bus.rx_data == CMD_SETN) && (plen_q != 8'd1)) ||
                         ((bus.rx_data == CMD_RES)  && (plen_q != 8'd0)) ||
                         ((bus.rx_data == CMD_MAT)  &&
                          ((n_value_q == 4'd0) || (plen_q != n_sq_c)))) begin
              err_d      = 1'b1;
              err_code_d = E_LEN;
              state_d    = S_DISCARD;
            end
          end
          S_PAYLOAD: begin
            plen_d  = plen_q - 8'd1;
            state_d = (plen_d == 8'd0) ? S_END : S_PAYLOAD;
            if (cmd_q == CMD_SETN) begin
              if ((bus.rx_data >= 8'd1) && (bus.rx_data <= 8'(N_MAX))) begin
                n_cand_d = 4'(bus.rx_data);
              end else begin
                err_d      = 1'b1;
                err_code_d = E_CMD;
                state_d    = S_DISCARD;
              end
            end else if (bus.mat_full) begin
              err_d       = 1'b1;
              err_code_d  = E_OVF;
              mat_abort_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              mat_push_d = 1'b1;
              mat_data_d = bus.rx_data;
            end
          end
          S_END: begin
            state_d = S_IDLE;
            if (bus.rx_data == END_BYTE) begin
              if (cmd_q == CMD_SETN) begin
                n_value_d = n_cand_q;
                n_valid_d = 1'b1;
              end
              result_req_d = (cmd_q == CMD_RES);
              mat_done_d   = (cmd_q == CMD_MAT);
            end else begin
              err_d       = 1'b1;
              err_code_d  = E_END;
              mat_abort_d = (cmd_q == CMD_MAT);
            end
          end
          S_DISCARD: begin
            if (plen_q == 8'd0) state_d = S_IDLE;
            else                plen_d  = plen_q - 8'd1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (tmo_fire_c) begin
      err_d       = 1'b1;
      err_code_d  = E_TMO;
      mat_abort_d = mat_active_c;
      state_d     = S_IDLE;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mat_push   = mat_push_q;
  assign bus.mat_data   = mat_data_q;
  assign bus.mat_done   = mat_done_q;
  assign bus.mat_abort  = mat_abort_q;
  assign bus.n_value    = n_value_q;
  assign bus.n_valid    = n_valid_q;
  assign bus.result_req = result_req_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames queue expected pulses, a monitor pops and compares.
module tb_uart_cmd_parser;
  localparam logic [2:0] K_PUSH  = 3'd0;
  localparam logic [2:0] K_NV    = 3'd1;
  localparam logic [2:0] K_RES   = 3'd2;
  localparam logic [2:0] K_DONE  = 3'd3;
  localparam logic [2:0] K_ABORT = 3'd4;
  localparam logic [2:0] K_ERR   = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus();
  uart_cmd_parser dut (.clk(clk), .reset(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic observe(input logic [2:0] k, input logic [7:0] v);
    logic [10:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d val %02h, expected none", k, v);
    end else begin
      e = exp_q.pop_front();
      if (e != {k, v}) begin
        n_bad++;
        $display("FAIL event: got kind %0d val %02h, expected kind %0d val %02h",
                 k, v, e[10:8], e[7:0]);
      end
    end
  endtask

  // Monitor: fixed intra-cycle order push, n_valid, result_req, done, abort, err.
  always @(negedge clk) begin
    if (bus.mat_push)   observe(K_PUSH, bus.mat_data);
    if (bus.n_valid)    observe(K_NV, {4'd0, bus.n_value});
    if (bus.result_req) observe(K_RES, 8'd0);
    if (bus.mat_done)   observe(K_DONE, 8'd0);
    if (bus.mat_abort)  observe(K_ABORT, 8'd0);
    if (bus.err)        observe(K_ERR, {5'd0, bus.err_code});
  end

  task automatic send(input logic [7:0] d, input logic par, input logic full);
    @(posedge clk); #1;
    bus.rx_data = d; bus.rx_valid = 1'b1; bus.rx_parity_err = par; bus.mat_full = full;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0; bus.rx_parity_err = 1'b0; bus.mat_full = 1'b0;
  endtask

  task automatic sb(input logic [7:0] d);
    send(d, 1'b0, 1'b0);
  endtask

  task automatic set_n(input logic [7:0] v, input logic ok);
    sb(8'hFE); sb(8'h03); sb(8'h01);
    if (!ok) expect_ev(K_ERR, 8'd3);
    sb(v);
    if (ok) expect_ev(K_NV, v);
    sb(8'hEF);
  endtask

  task automatic res_req(input logic [7:0] l);
    sb(8'hFE); sb(l); sb(8'h02);
    expect_ev(K_RES, 8'd0);
    sb(8'hEF);
  endtask

  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_parity_err = 1'b0; bus.mat_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_n_value", int'(bus.n_value), 0);
    check("reset_err_code", int'(bus.err_code), 0);
    check("reset_pulses", int'({bus.mat_push, bus.err, bus.n_valid, bus.mat_done}), 0);
    rst_n = 1'b1;

    // Set N=4
    set_n(8'h04, 1'b1);
    check("n_after_set4", int'(bus.n_value), 4);
    check("busy_after_set", int'(bus.busy), 0);

    // Full 4x4 matrix
    sb(8'hFE); sb(8'h12); sb(8'h04);
    for (int i = 0; i < 16; i++) begin
      expect_ev(K_PUSH, 8'(i));
      sb(8'(i));
    end
    expect_ev(K_DONE, 8'd0);
    sb(8'hEF);

    // Result requests with L=1 and L=2
    res_req(8'h01);
    check("busy_between_res", int'(bus.busy), 0);
    res_req(8'h02);

    // Bad END keeps N, then N=2
    sb(8'hFE); sb(8'h03); sb(8'h01); sb(8'h05);
    expect_ev(K_ERR, 8'd2);
    sb(8'hAA);
    check("n_kept_bad_end", int'(bus.n_value), 4);
    check("err_code_held", int'(bus.err_code), 2);
    set_n(8'h02, 1'b1);
    check("n_after_set2", int'(bus.n_value), 2);

    // Matrix overflow on 5th byte, then a clean frame
    set_n(8'h04, 1'b1);
    sb(8'hFE); sb(8'h12); sb(8'h04);
    for (int i = 0; i < 4; i++) begin
      expect_ev(K_PUSH, 8'(i));
      sb(8'(i));
    end
    expect_ev(K_ABORT, 8'd0);
    expect_ev(K_ERR, 8'd5);
    send(8'h04, 1'b0, 1'b1);
    check("busy_after_ovf", int'(bus.busy), 0);
    res_req(8'h02);

    // Parity error on CMD; trailing bytes ignored in IDLE
    sb(8'hFE); sb(8'h03);
    expect_ev(K_ERR, 8'd1);
    send(8'h01, 1'b1, 1'b0);
    check("busy_after_parity", int'(bus.busy), 0);
    sb(8'h04); sb(8'hEF);

    // Unknown CMD, length mismatch, N range boundaries
    sb(8'hFE); sb(8'h02);
    expect_ev(K_ERR, 8'd3);
    sb(8'h07); sb(8'hEF);
    sb(8'hFE); sb(8'h04);
    expect_ev(K_ERR, 8'd4);
    sb(8'h01); sb(8'h05); sb(8'h06); sb(8'hEF);
    check("busy_after_discard", int'(bus.busy), 0);
    set_n(8'h09, 1'b0);
    set_n(8'h00, 1'b0);
    check("n_kept_range", int'(bus.n_value), 4);
    set_n(8'h08, 1'b1);
    sb(8'hFE); sb(8'h04);
    expect_ev(K_ERR, 8'd4);
    sb(8'h04); sb(8'h00); sb(8'h00); sb(8'hEF);

    // FE with parity error in IDLE is ignored; L=0 accepted
    send(8'hFE, 1'b1, 1'b0);
    res_req(8'h00);

    // N=1: START byte as data, parity in payload, bad END on matrix
    set_n(8'h01, 1'b1);
    sb(8'hFE); sb(8'h03); sb(8'h04);
    expect_ev(K_PUSH, 8'hFE);
    sb(8'hFE);
    expect_ev(K_DONE, 8'd0);
    sb(8'hEF);
    sb(8'hFE); sb(8'h03); sb(8'h04);
    expect_ev(K_ABORT, 8'd0);
    expect_ev(K_ERR, 8'd1);
    send(8'hAA, 1'b1, 1'b0);
    sb(8'hFE); sb(8'h03); sb(8'h04);
    expect_ev(K_PUSH, 8'h11);
    sb(8'h11);
    expect_ev(K_ABORT, 8'd0);
    expect_ev(K_ERR, 8'd2);
    sb(8'h00);

    // Asynchronous reset mid-frame
    sb(8'hFE); sb(8'h03);
    check("busy_in_frame", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("busy_async_reset", int'(bus.busy), 0);
    check("n_async_reset", int'(bus.n_value), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Matrix command with N=0 rejected
    sb(8'hFE); sb(8'h02);
    expect_ev(K_ERR, 8'd4);
    sb(8'h04); sb(8'hEF);
    check("busy_final", int'(bus.busy), 0);

`ifdef UART_CMD_TIMEOUT_EN
    sb(8'hFE); sb(8'h03);
    expect_ev(K_ERR, 8'd6);
    repeat (70) @(posedge clk);
    #1;
    check("busy_after_timeout", int'(bus.busy), 0);
    check("err_code_timeout", int'(bus.err_code), 6);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    while (exp_q.size() != 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got none, expected kind %0d val %02h", e[10:8], e[7:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
